// File: rtl/axi_param_fetch.sv
// axi_param_fetch: AXI4 read-only burst master filling a local parameter cache.
// Ports: clk/reset, start/base_addr/num_words request, busy/done/error status,
//   AR and R channels (o_axi_* / i_axi_*), and a registered cache read port.
module axi_param_fetch #(
  parameter int C_AXI_ADDR_WIDTH = 12,
  parameter int C_AXI_DATA_WIDTH = 128,
  parameter int C_AXI_ID_WIDTH   = 1,
  parameter int C_SIZE_OF_CACHE  = 64,
  parameter int MAX_BURST_LENGTH = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [C_AXI_ADDR_WIDTH-1:0]       base_addr,
  input  logic [$clog2(C_SIZE_OF_CACHE):0]  num_words,
  output logic                              busy,
  output logic                              done,
  output logic                              error,
  output logic [C_AXI_ID_WIDTH-1:0]         o_axi_arid,
  output logic [C_AXI_ADDR_WIDTH-1:0]       o_axi_araddr,
  output logic [7:0]                        o_axi_arlen,
  output logic [2:0]                        o_axi_arsize,
  output logic [1:0]                        o_axi_arburst,
  output logic                              o_axi_arvalid,
  input  logic                              i_axi_arready,
  input  logic [C_AXI_ID_WIDTH-1:0]         i_axi_rid,
  input  logic [C_AXI_DATA_WIDTH-1:0]       i_axi_rdata,
  input  logic [1:0]                        i_axi_rresp,
  input  logic                              i_axi_rlast,
  input  logic                              i_axi_rvalid,
  output logic                              o_axi_rready,
  input  logic [$clog2(C_SIZE_OF_CACHE)-1:0] cache_rd_addr,
  output logic [C_AXI_DATA_WIDTH-1:0]       cache_rd_data
);

  localparam int BB = C_AXI_DATA_WIDTH / 8;
  localparam int SZ = $clog2(BB);
  localparam int CW = $clog2(C_SIZE_OF_CACHE);
  localparam int NW = CW + 1;
  localparam int AW = C_AXI_ADDR_WIDTH;
  localparam int LW = (AW < 12) ? AW : 12;
  localparam int EW = AW + NW + SZ + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] DATA = 2'd2;
  localparam logic [1:0] FIN  = 2'd3;

  logic [1:0]    state;
  logic [AW-1:0] addr;
  logic [NW-1:0] remaining;
  logic [CW-1:0] wr_ptr;
  logic [8:0]    beat_cnt;
  logic [8:0]    beats;

  logic [C_AXI_DATA_WIDTH-1:0] mem [C_SIZE_OF_CACHE];

  logic [AW-1:0] nx_addr;
  logic [NW-1:0] nx_rem;
  logic [AW-1:0] burst_bytes;
  logic [11:0]   page_off;
  logic [12:0]   page_words;
  logic [12:0]   calc;
  logic [8:0]    nx_beats;
  logic [EW-1:0] end_addr;
  logic          bad;
  logic          beat;
  logic          last;

  assign o_axi_arid    = '0;
  assign o_axi_arsize  = 3'(SZ);
  assign o_axi_arburst = 2'b01;
  assign busy = (state == ADDR) || (state == DATA);
  assign done = (state == FIN);

  assign beat = (state == DATA) && i_axi_rvalid && o_axi_rready;
  assign last = (beat_cnt == {1'b0, o_axi_arlen});
  assign burst_bytes = AW'(beats) << SZ;

  // Next-burst sizing is computed from the values the address and
  // word count will hold once the transition into ADDR takes effect,
  // so the AR payload can be registered on that same edge.
  always_comb begin
    if (state == IDLE) begin
      nx_addr = base_addr;
      nx_rem  = num_words;
    end else begin
      nx_addr = addr + burst_bytes;
      nx_rem  = remaining - 1'b1;
    end
    page_off   = 12'(nx_addr[LW-1:0]);
    page_words = (13'd4096 - {1'b0, page_off}) >> SZ;
    calc = 13'(nx_rem);
    if (calc > 13'(MAX_BURST_LENGTH))
      calc = 13'(MAX_BURST_LENGTH);
    if (calc > page_words)
      calc = page_words;
    nx_beats = calc[8:0];
  end

  always_comb begin
    end_addr = EW'(base_addr) + (EW'(num_words) << SZ);
    bad = (num_words > NW'(C_SIZE_OF_CACHE))
       || (end_addr > (EW'(1) << AW));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      o_axi_arvalid <= 1'b0;
      o_axi_rready  <= 1'b0;
      o_axi_araddr  <= '0;
      o_axi_arlen   <= '0;
      error         <= 1'b0;
      addr          <= '0;
      remaining     <= '0;
      wr_ptr        <= '0;
      beat_cnt      <= '0;
      beats         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= num_words;
            wr_ptr    <= '0;
            error     <= bad;
            if (bad || num_words == '0) begin
              state <= FIN;
            end else begin
              state         <= ADDR;
              o_axi_arvalid <= 1'b1;
              o_axi_araddr  <= nx_addr;
              o_axi_arlen   <= 8'(nx_beats - 9'd1);
              beats         <= nx_beats;
            end
          end
        end
        ADDR: begin
          if (i_axi_arready) begin
            o_axi_arvalid <= 1'b0;
            o_axi_rready  <= 1'b1;
            beat_cnt      <= '0;
            state         <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            wr_ptr    <= wr_ptr + 1'b1;
            remaining <= nx_rem;
            beat_cnt  <= beat_cnt + 9'd1;
            if (i_axi_rresp != 2'b00)
              error <= 1'b1;
            // A misplaced or missing rlast is flagged, but the burst
            // length we asked for is what terminates the burst.
            if (i_axi_rlast != last)
              error <= 1'b1;
            if (last) begin
              o_axi_rready <= 1'b0;
              addr         <= nx_addr;
              if (nx_rem != '0) begin
                state         <= ADDR;
                o_axi_arvalid <= 1'b1;
                o_axi_araddr  <= nx_addr;
                o_axi_arlen   <= 8'(nx_beats - 9'd1);
                beats         <= nx_beats;
              end else begin
                state <= FIN;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && beat)
      mem[wr_ptr] <= i_axi_rdata;
    cache_rd_data <= mem[cache_rd_addr];
  end

  logic unused_ok;
  assign unused_ok = ^{i_axi_rid, calc[12:9]};

endmodule

// File: tb/tb_axi_param_fetch.sv
// tb_axi_param_fetch: randomized scoreboard bench for axi_param_fetch.
// A behavioural AXI slave RAM serves bursts; expectations are queued at issue.
module tb_axi_param_fetch;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [11:0]  base_addr = '0;
  logic [6:0]   num_words = '0;
  logic         busy, done, error;
  logic [0:0]   arid;
  logic [11:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready = 1'b0;
  logic [0:0]   rid = '0;
  logic [127:0] rdata = '0;
  logic [1:0]   rresp = '0;
  logic         rlast = 1'b0;
  logic         rvalid = 1'b0;
  logic         rready;
  logic [5:0]   cache_rd_addr = '0;
  logic [127:0] cache_rd_data;

  axi_param_fetch dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .num_words(num_words),
    .busy(busy), .done(done), .error(error),
    .o_axi_arid(arid), .o_axi_araddr(araddr),
    .o_axi_arlen(arlen), .o_axi_arsize(arsize),
    .o_axi_arburst(arburst), .o_axi_arvalid(arvalid),
    .i_axi_arready(arready), .i_axi_rid(rid),
    .i_axi_rdata(rdata), .i_axi_rresp(rresp),
    .i_axi_rlast(rlast), .i_axi_rvalid(rvalid),
    .o_axi_rready(rready),
    .cache_rd_addr(cache_rd_addr),
    .cache_rd_data(cache_rd_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  logic [127:0] ram [256];
  int exp_addr[$];
  int exp_len[$];
  bit exp_err[$];

  bit stall_en = 0;
  int err_beat = -1;
  int g_cnt = 0;
  int ar_cycles = 0;

  // Reference: split the request into bursts from the plain rules.
  task automatic issue(input int base, input int num);
    bit bad;
    int a, r, bt, pg;
    bad = (num > 64) || (base + num * 16 > 4096);
    if (!bad) begin
      a = base;
      r = num;
      while (r > 0) begin
        bt = (r > 16) ? 16 : r;
        pg = (4096 - (a % 4096)) / 16;
        if (bt > pg) bt = pg;
        exp_addr.push_back(a);
        exp_len.push_back(bt - 1);
        a += bt * 16;
        r -= bt;
      end
    end
    exp_err.push_back(bad || (err_beat >= 0 && err_beat < num));
    g_cnt = 0;
    @(negedge clk);
    base_addr = 12'(base);
    num_words = 7'(num);
    start = 1'b1;
  endtask

  task automatic run_req(input int base, input int num);
    bit bad, got;
    int ar0;
    bad = (num > 64) || (base + num * 16 > 4096);
    ar0 = ar_cycles;
    issue(base, num);
    @(negedge clk);
    start = 1'b0;
    if (bad || num == 0) begin
      check("done_latency", done, 1);
    end else begin
      check("busy_after_start", busy, 1);
      check("error_cleared", error, 0);
    end
    got = 0;
    for (int k = 0; k < 5000 && !got; k++) begin
      if (done) got = 1;
      else @(negedge clk);
    end
    check("done_seen", got, 1);
    check("busy_at_done", busy, 0);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    if (bad || num == 0)
      check("no_ar_traffic", ar_cycles, ar0);
    if (!bad) begin
      for (int i = 0; i < num; i++) begin
        cache_rd_addr = 6'(i);
        @(negedge clk);
        check($sformatf("cache[%0d]", i), cache_rd_data,
              ram[base / 16 + i]);
      end
    end
  endtask

  // AXI slave model; drives on negedges, DUT samples on posedges.
  initial begin : slave
    bit bact, ar_seen;
    int stall, rstall, b_addr, b_len, b_cnt;
    int h_addr, h_len;
    bact = 0; ar_seen = 0; stall = 0; rstall = 0;
    b_addr = 0; b_len = 0; b_cnt = 0; h_addr = 0; h_len = 0;
    forever begin
      @(negedge clk);
      arready = 1'b0;
      rvalid = 1'b0;
      rlast = 1'b0;
      rresp = 2'b00;
      if (reset) begin
        bact = 0;
        ar_seen = 0;
      end else if (!bact) begin
        if (arvalid) begin
          ar_cycles++;
          if (ar_seen) begin
            check("ar_addr_stable", araddr, 128'(h_addr));
            check("ar_len_stable", arlen, 128'(h_len));
          end else begin
            ar_seen = 1;
            h_addr = int'(araddr);
            h_len = int'(arlen);
            stall = stall_en ? $urandom_range(0, 5) : 0;
          end
          if (stall > 0) begin
            stall--;
          end else begin
            arready = 1'b1;
            ar_seen = 0;
            bact = 1;
            b_addr = int'(araddr);
            b_len = int'(arlen);
            b_cnt = 0;
            rstall = stall_en ? $urandom_range(0, 5) : 0;
            check("ar_size", arsize, 4);
            check("ar_burst", arburst, 1);
            if (exp_addr.size() == 0) begin
              check("ar_unexpected", 1, 0);
            end else begin
              check("ar_addr", araddr, 128'(exp_addr.pop_front()));
              check("ar_len", arlen, 128'(exp_len.pop_front()));
            end
          end
        end
      end else if (rready) begin
        if (rstall > 0) begin
          rstall--;
        end else begin
          rvalid = 1'b1;
          rdata = ram[(b_addr / 16 + b_cnt) % 256];
          rlast = (b_cnt == b_len);
          rresp = (g_cnt == err_beat) ? 2'b10 : 2'b00;
          g_cnt++;
          if (b_cnt == b_len) bact = 0;
          b_cnt++;
          rstall = stall_en ? $urandom_range(0, 5) : 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_err.size() == 0)
        check("done_unexpected", 1, 0);
      else
        check("done_error", error, 128'(exp_err.pop_front()));
    end
  end

  initial begin : stim
    bit got;
    for (int i = 0; i < 256; i++)
      ram[i] = {$urandom, $urandom, $urandom, $urandom};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arlen", arlen, 0);
    check("rst_arid", arid, 0);
    reset = 1'b0;

    run_req(12'h000, 40);
    run_req(12'h000, 0);
    run_req(12'h000, 65);
    run_req(12'h200, 3);
    run_req(12'hF80, 8);
    run_req(12'hF80, 9);

    err_beat = 4;
    run_req(12'h300, 8);
    err_beat = -1;

    stall_en = 1;
    run_req(12'h000, 40);
    for (int t = 0; t < 6; t++)
      run_req($urandom_range(0, 255) * 16, $urandom_range(0, 70));

    issue(12'h000, 40);
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int k = 0; k < 5000 && !got; k++) begin
      if (g_cnt >= 20) got = 1;
      else @(negedge clk);
    end
    check("mid_burst2_reached", got, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_addr.delete();
    exp_len.delete();
    exp_err.delete();
    repeat (2) @(negedge clk);
    check("midrst_arvalid", arvalid, 0);
    check("midrst_rready", rready, 0);
    check("midrst_busy", busy, 0);
    reset = 1'b0;
    stall_en = 0;
    run_req(12'h100, 4);

    check("ar_queue_empty", 128'(exp_addr.size()), 0);
    check("err_queue_empty", 128'(exp_err.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
